// File: rtl/method9_driver.sv
`timescale 1ns/1ps
// Drives one ActionValue method call at a time for an upstream request stream
// and queues the returned values in a small response FIFO.
module method9_driver #(
  parameter int RSP_DEPTH = 4,
  parameter int STALL_MAX = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_data,
  input  logic        RDY_ifcA_method9,
  output logic        EN_ifcA_method9,
  output logic [3:0]  ifcA_method9_in1,
  input  logic [3:0]  ifcA_method9,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_data,
  output logic [15:0] call_cnt,
  output logic [7:0]  stall_cnt
);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(RSP_DEPTH);
  localparam logic [7:0]       STALL_MAX_C = 8'(STALL_MAX);

  typedef enum logic {IDLE, PEND} state_t;

  state_t           state, stateNext;
  logic [3:0]       argQ;
  logic [3:0]       rspMem [RSP_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] rspCount;
  logic [15:0]      callCnt;
  logic [7:0]       stallCnt;
  logic             fire, reqRdy, accept, pop, rspVld, stallInc;

  // Handshake decode; occupancy is the start-of-cycle value, so a full FIFO
  // blocks fire even when the head is popped in the same cycle.
  always_comb begin
    fire      = 1'b0;
    reqRdy    = 1'b0;
    accept    = 1'b0;
    pop       = 1'b0;
    stallInc  = 1'b0;
    stateNext = state;
    rspVld    = (rspCount != '0);
    fire      = (state == PEND) && RDY_ifcA_method9 && (rspCount < DEPTH_C) && !flush && !RST;
    reqRdy    = !flush && ((state == IDLE) || fire);
    accept    = req_valid && reqRdy;
    pop       = rspVld && rsp_ready;
    stallInc  = (state == PEND) && !RDY_ifcA_method9 && !flush && (stallCnt != STALL_MAX_C);
    if (flush)       stateNext = IDLE;
    else if (accept) stateNext = PEND;
    else if (fire)   stateNext = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  // Control registers: held argument, FIFO pointers/occupancy, counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      argQ     <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      rspCount <= '0;
      callCnt  <= '0;
      stallCnt <= '0;
    end else begin
      if (accept)   argQ     <= req_data;
      if (fire)     callCnt  <= callCnt + 16'd1;
      if (stallInc) stallCnt <= stallCnt + 8'd1;
      if (flush) begin
        wrPtr    <= '0;
        rdPtr    <= '0;
        rspCount <= '0;
      end else begin
        if (fire) wrPtr <= wrPtr + 1'b1;
        if (pop)  rdPtr <= rdPtr + 1'b1;
        case ({fire, pop})
          2'b10:   rspCount <= rspCount + 1'b1;
          2'b01:   rspCount <= rspCount - 1'b1;
          default: rspCount <= rspCount;
        endcase
      end
    end
  end

  // Response storage holds data only; validity lives in rspCount
  always_ff @(posedge CLK) begin
    if (fire) rspMem[wrPtr] <= ifcA_method9;
  end

  assign EN_ifcA_method9  = fire;
  assign ifcA_method9_in1 = argQ;
  assign req_ready        = reqRdy;
  assign rsp_valid        = rspVld;
  assign rsp_data         = rspVld ? rspMem[rdPtr] : 4'h0;
  assign call_cnt         = callCnt;
  assign stall_cnt        = stallCnt;
endmodule
